mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Shares one 4-bit output channel between four requesters.
- Picks a winner by round-robin and steers that requester's data through the team's 4:1 4-bit mux (MUX) into a registered valid/ready output stage.
- Sits in front of any single-consumer sink that needs fair access from four 4-bit sources.
- Supports per-requester lock, so a requester can keep the channel for back-to-back beats.

Parameters:
- DATA_W, 4: data width per requester and output; fixed at 4 to match MUX.
- NREQ, 4: number of requesters; fixed at 4, and the 2-bit select encoding depends on it.

Ports:
- clk  input  1  single clock, rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- req  input  4  request per requester; bit i = requester i.
- lock  input  4  bit i high = requester i keeps priority after winning.
- data0  input  4  requester 0 data.
- data1  input  4  requester 1 data.
- data2  input  4  requester 2 data.
- data3  input  4  requester 3 data.
- gnt  output  4  one-hot beat accept, combinational; requester i's data is taken this cycle.
- out_data  output  4  registered winner data.
- out_valid  output  1  out_data holds an unconsumed beat.
- out_ready  input  1  sink accepts out_data this cycle.
- out_sel  output  2  index of the requester whose beat is in out_data.

Behaviour:
- Reset: reset_L low asynchronously forces out_valid=0, out_data=0, out_sel=0, ptr=0, last_lock=0.
  - gnt=0 while reset_L is low.
  - A beat in flight when reset asserts is dropped; no gnt is issued.
- Output-stage states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load = (state==EMPTY) | out_ready.
- Arbitration is combinational each cycle:
  - Search req starting at index ptr, upward, wrapping 3->0.
  - First set bit = winner w. If req==0, there is no winner.
- Capture: on load with a winner:
  - gnt = onehot(w) in the same cycle.
  - Next edge: out_data <= data_w (selected via MUX with select=w), out_sel <= w, out_valid <= 1.
- Pointer update on capture:
  - lock[w]=1: ptr <= w.
  - lock[w]=0: ptr <= w+1 mod 4.
- No capture cases:
  - load with no winner: gnt=0. If FULL and out_ready, go to EMPTY (out_valid <= 0). ptr unchanged.
  - FULL with out_ready=0: gnt=0, all output registers hold, ptr unchanged, regardless of req.
- Simultaneous out_ready and new winner: the old beat is consumed and the new beat loaded in the same edge. Throughput is 1 beat/cycle, with no bubble.
- Latency: gnt in cycle N, beat visible on out_data/out_valid in cycle N+1.
- A requester must hold data_i stable while req_i=1 and gnt_i=0. It may change data or drop req the cycle after gnt_i.
- Dropping req_i before grant is legal; the arbiter never grants a deasserted request.
- Fairness: with lock=0, each continuously requesting source is granted within 4 captures.
- lock is sampled only for the winner at capture time.

Decomposition:
- Shared package constants: DATA_W=4, NREQ=4, SEL_W=2, state encoding (EMPTY=0, FULL=1).
- Shared package function: onehot2 (2-bit index -> 4-bit one-hot).
- Sub-module: instantiate MUX for data steering with select = combinational winner index.
- Round-robin priority search stays inline (fixed 4 entries).

Test Plan:
- Reset mid-beat: out_valid=1, out_data=0xA, reset_L pulsed low off-edge -> outputs zero immediately, gnt=0; after release with req=0, out_valid stays 0.
- Single requester: req=0100, data2=0x5, out_ready=1 -> gnt=0100 in cycle N; cycle N+1 out_data=0x5, out_sel=2, out_valid=1; ptr becomes 3.
- Round-robin: req=1111 held, lock=0, data i = 0x1+i, out_ready=1 from reset -> out_sel sequence 0,1,2,3,0, one beat per cycle, gnt one-hot each cycle.
- Backpressure: out_ready=0 with FULL and req=1111 -> gnt=0, out_data/out_sel frozen for 5 cycles; out_ready=1 -> next beat from ptr, no lost or duplicated beat.
- Lock: req=1011, lock=0001 with requester 0 winning -> requester 0 granted 3 consecutive beats; lock0 dropped -> next grants 1 then 3 (2 skipped, not requesting).
- Wrap and idle: ptr=3, req=0001 -> winner 0 (wrap); then req=0 with out_ready=1 -> out_valid falls to 0 the next cycle, ptr stays 1.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and helpers for the 4-way round-robin arbiter.
// Holds data/select widths, the output-stage state encoding and onehot2.
package mux4_rr_arbiter_pkg;

    localparam int DATA_W = 4;
    localparam int NREQ   = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostate_t;

    function automatic logic [NREQ-1:0] onehot2(
        input logic [SEL_W-1:0] idx
    );
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux.sv
// 4:1 data mux, DATA_W bits wide.
// Steers the selected requester's data toward the output register.
module mux4_rr_arbiter_mux
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    output logic [DATA_W-1:0] y
);

    // Pure select; every encoding of sel is covered.
    always_comb begin
        unique case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4-bit channel among four requesters.
// Combinational grant, registered valid/ready output stage, per-source lock.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset_L,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    output logic [NREQ-1:0]   gnt,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_sel
);

    ostate_t           state;
    logic [SEL_W-1:0]  last_w;
    logic              last_lock;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  win;
    logic [SEL_W-1:0]  idx;
    logic              found;
    logic              load;
    logic [DATA_W-1:0] mux_y;

    // The search start is derived from the last winner and its lock bit.
    // last_w resets to 3 so that the derived start is 0 out of reset.
    assign ptr = last_lock ? last_w : last_w + SEL_W'(1);

    assign load = (state == ST_EMPTY) | out_ready;

    assign out_valid = (state == ST_FULL);

    // First requesting index at or after ptr, wrapping 3 -> 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Grant only when the beat will actually be captured this cycle.
    always_comb begin
        gnt = '0;
        if (reset_L && load && found) begin
            gnt = onehot2(win);
        end
    end

    mux4_rr_arbiter_mux u_mux (
        .sel (win),
        .d0  (data0),
        .d1  (data1),
        .d2  (data2),
        .d3  (data3),
        .y   (mux_y)
    );

    // Output-stage FSM: capture on load with a winner, drain on load without.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= ST_EMPTY;
            out_data  <= '0;
            out_sel   <= '0;
            last_w    <= SEL_W'(3);
            last_lock <= 1'b0;
        end else if (load) begin
            if (found) begin
                state     <= ST_FULL;
                out_data  <= mux_y;
                out_sel   <= win;
                last_w    <= win;
                last_lock <= lock[win];
            end else begin
                state     <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter.
// Reference model checked every cycle plus hand-computed literal checks.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       reset_L;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] data0;
    logic [3:0] data1;
    logic [3:0] data2;
    logic [3:0] data3;
    logic [3:0] gnt;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_sel;

    int total = 0;
    int bad   = 0;

    int       m_ptr   = 0;
    logic     m_valid = 1'b0;
    logic [3:0] m_data = 4'h0;
    int       m_sel   = 0;

    mux4_rr_arbiter dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .req       (req),
        .lock      (lock),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .gnt       (gnt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: compare at negedge, then advance to post-edge state.
    always @(negedge clk) begin
        logic [3:0] d [4];
        logic [3:0] eg;
        int  w;
        bit  ld;
        d[0] = data0; d[1] = data1; d[2] = data2; d[3] = data3;
        eg = 4'b0;
        w  = -1;
        if (!reset_L) begin
            m_valid = 1'b0; m_data = 4'h0; m_sel = 0; m_ptr = 0;
        end
        ld = !m_valid || out_ready;
        if (reset_L && ld) begin
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
            if (w >= 0) eg[w] = 1'b1;
        end
        chk("m_gnt", gnt, eg);
        chk("m_valid", out_valid, m_valid);
        chk("m_data", out_data, m_data);
        chk("m_sel", out_sel, m_sel);
        if (reset_L && ld) begin
            if (w >= 0) begin
                m_valid = 1'b1;
                m_data  = d[w];
                m_sel   = w;
                m_ptr   = lock[w] ? w : (w + 1) % 4;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        reset_L = 1'b0; req = 4'b0; lock = 4'b0; out_ready = 1'b0;
        data0 = 4'h0; data1 = 4'h0; data2 = 4'h0; data3 = 4'h0;
        step(); step();
        chk("rst_valid", out_valid, 1'b0);
        reset_L = 1'b1;

        // Single requester 2.
        req = 4'b0100; data2 = 4'h5; out_ready = 1'b1;
        #1 chk("single_gnt", gnt, 4'b0100);
        step(); req = 4'b0;
        chk("single_data", out_data, 4'h5);
        chk("single_sel", out_sel, 2'd2);
        chk("single_valid", out_valid, 1'b1);

        // ptr is 3; only requester 0 asks -> wraps to 0.
        req = 4'b0001; data0 = 4'h1;
        #1 chk("wrap_gnt", gnt, 4'b0001);
        step(); req = 4'b0;
        chk("wrap_sel", out_sel, 2'd0);
        chk("wrap_data", out_data, 4'h1);
        #1 chk("idle_gnt", gnt, 4'b0000);
        step();
        chk("idle_valid", out_valid, 1'b0);

        // Reset mid-beat.
        req = 4'b0010; data1 = 4'hA;
        #1 chk("rb_gnt", gnt, 4'b0010);
        step(); req = 4'b1111; out_ready = 1'b0;
        chk("rb_valid", out_valid, 1'b1);
        chk("rb_data", out_data, 4'hA);
        #1 reset_L = 1'b0;
        #1;
        chk("rst_valid2", out_valid, 1'b0);
        chk("rst_data2", out_data, 4'h0);
        chk("rst_sel2", out_sel, 2'd0);
        chk("rst_gnt2", gnt, 4'b0000);
        step(); step();
        reset_L = 1'b1; req = 4'b0;
        step();
        chk("post_rst_valid", out_valid, 1'b0);

        // Round-robin, all requesting, from ptr 0.
        data0 = 4'h1; data1 = 4'h2; data2 = 4'h3; data3 = 4'h4;
        req = 4'b1111; lock = 4'b0; out_ready = 1'b1;
        #1 chk("rr_gnt0", gnt, 4'b0001);
        step(); chk("rr_sel0", out_sel, 2'd0); chk("rr_gnt1", gnt, 4'b0010);
        step(); chk("rr_sel1", out_sel, 2'd1); chk("rr_gnt2", gnt, 4'b0100);
        step(); chk("rr_sel2", out_sel, 2'd2); chk("rr_gnt3", gnt, 4'b1000);
        step(); chk("rr_sel3", out_sel, 2'd3); chk("rr_gnt4", gnt, 4'b0001);
        step(); chk("rr_sel4", out_sel, 2'd0); chk("rr_data4", out_data, 4'h1);

        // Backpressure for 5 cycles, then resume from ptr 1.
        out_ready = 1'b0;
        #1 chk("bp_gnt", gnt, 4'b0000);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_sel", out_sel, 2'd0);
            chk("bp_data", out_data, 4'h1);
            chk("bp_gnt_h", gnt, 4'b0000);
        end
        out_ready = 1'b1;
        #1 chk("bp_resume_gnt", gnt, 4'b0010);
        step();
        chk("bp_resume_sel", out_sel, 2'd1);
        chk("bp_resume_data", out_data, 4'h2);

        // Move ptr to 0 via requester 3, then lock on requester 0.
        req = 4'b1000;
        step();
        chk("pre_lock_sel", out_sel, 2'd3);
        req = 4'b1011; lock = 4'b0001;
        #1 chk("lk_gnt0", gnt, 4'b0001);
        step(); chk("lk_sel0", out_sel, 2'd0); chk("lk_gnt1", gnt, 4'b0001);
        step(); chk("lk_sel1", out_sel, 2'd0);
        lock = 4'b0;
        #1 chk("lk_gnt2", gnt, 4'b0001);
        step(); chk("lk_sel2", out_sel, 2'd0); chk("lk_gnt3", gnt, 4'b0010);
        step(); chk("lk_sel3", out_sel, 2'd1); chk("lk_gnt4", gnt, 4'b1000);
        step(); chk("lk_sel4", out_sel, 2'd3); chk("lk_data4", out_data, 4'h4);

        req = 4'b0;
        step(); step();
        chk("end_valid", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
